// File: rtl/decode_trace_buffer.sv
// Epoch-tagged FIFO for the stage-2 decoder trace: captures packets, purges
// entries squashed by an epoch change, and hands the survivors to the checker.
module decode_trace_buffer #(
   parameter int DEPTH = 8,
   parameter int PKT_W = 66,
   parameter int CNT_W = 16
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         in_valid,
   input  logic [PKT_W-1:0]             in_packet,
   input  logic                         en_update_eepoch,
   input  logic                         en_update_wepoch,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PKT_W-1:0]             out_packet,
   output logic                         out_eepoch,
   output logic                         out_wepoch,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic [CNT_W-1:0]             ovf_cnt,
   output logic [CNT_W-1:0]             squash_cnt,
   input  logic                         clr_stats
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [PKT_W-1:0] pkt;
      logic             e;
      logic             w;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            e_epoch;
   logic            w_epoch;

   entry_t head;
   logic   not_empty;
   logic   head_cur;
   logic   head_stale;
   logic   push;
   logic   pop;
   logic   drop;

   // Head is judged against the registered epochs, so a toggle only
   // retracts the head from the following cycle onward.
   always_comb begin
      head       = mem[rd_ptr];
      not_empty  = (count != '0);
      head_cur   = not_empty && ({head.e, head.w} == {e_epoch, w_epoch});
      head_stale = not_empty && !head_cur;
      push       = in_valid && (count != FULL);
      drop       = in_valid && (count == FULL);
      pop        = head_stale || (head_cur && out_ready);
   end

   assign out_valid  = head_cur;
   assign out_packet = head.pkt;
   assign out_eepoch = head.e;
   assign out_wepoch = head.w;

   // NOTE: storage array has no reset; emptiness is tracked by count alone.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= entry_t'{pkt: in_packet, e: e_epoch, w: w_epoch};
   end

   // NOTE: all state updates use non-blocking assignment so every register
   // samples the same pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         e_epoch    <= 1'b0;
         w_epoch    <= 1'b0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         ovf_cnt    <= '0;
         squash_cnt <= '0;
      end else begin
         if (en_update_eepoch) e_epoch <= ~e_epoch;
         if (en_update_wepoch) w_epoch <= ~w_epoch;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // Clear takes priority over any drop or squash in the same cycle.
         if (clr_stats) begin
            overflow   <= 1'b0;
            ovf_cnt    <= '0;
            squash_cnt <= '0;
         end else begin
            if (drop) begin
               overflow <= 1'b1;
               if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
            end
            if (head_stale && (squash_cnt != '1)) squash_cnt <= squash_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_decode_trace_buffer.sv
// Scoreboard bench for decode_trace_buffer: expected deliveries are queued at
// push time and matched against each accepted head packet.
module tb_decode_trace_buffer;

   localparam int DEPTH = 8;
   localparam int PKT_W = 66;
   localparam int CNT_W = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic               CLK = 1'b0;
   logic               RST_N = 1'b0;
   logic               in_valid = 1'b0;
   logic [PKT_W-1:0]   in_packet = '0;
   logic               en_update_eepoch = 1'b0;
   logic               en_update_wepoch = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [PKT_W-1:0]   out_packet;
   logic               out_eepoch;
   logic               out_wepoch;
   logic [CW-1:0]      count;
   logic               overflow;
   logic [CNT_W-1:0]   ovf_cnt;
   logic [CNT_W-1:0]   squash_cnt;
   logic               clr_stats = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   logic [PKT_W+1:0] exp_q [$];

   decode_trace_buffer #(.DEPTH(DEPTH), .PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .in_valid(in_valid), .in_packet(in_packet),
      .en_update_eepoch(en_update_eepoch), .en_update_wepoch(en_update_wepoch),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_packet(out_packet), .out_eepoch(out_eepoch), .out_wepoch(out_wepoch),
      .count(count), .overflow(overflow), .ovf_cnt(ovf_cnt),
      .squash_cnt(squash_cnt), .clr_stats(clr_stats)
   );

   initial forever #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [PKT_W-1:0] v, input bit keep, input logic e, input logic w);
      in_valid  = 1'b1;
      in_packet = v;
      if (keep) exp_q.push_back({v, e, w});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while (count != '0 && n < 40) begin
         tick();
         n++;
      end
      check("drain_timeout", 128'(count != '0), 128'(0));
      tick();
      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
   endtask

   // Handshake monitor: sampled mid-cycle, the transfer completes at the next edge.
   initial forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 128'({out_packet, out_eepoch, out_wepoch}), 128'(0));
         end else begin
            check("out_pkt_tags", 128'({out_packet, out_eepoch, out_wepoch}),
                  128'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      tick();
      tick();
      RST_N = 1'b1;
      check("rst_count", 128'(count), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_overflow", 128'(overflow), 128'(0));
      check("rst_ovf_cnt", 128'(ovf_cnt), 128'(0));
      check("rst_squash_cnt", 128'(squash_cnt), 128'(0));

      // Basic flow
      out_ready = 1'b1;
      push(66'h1, 1, 0, 0);
      check("basic_valid_rise", 128'(out_valid), 128'(1));
      check("basic_first_pkt", 128'(out_packet), 128'(66'h1));
      push(66'h2, 1, 0, 0);
      push(66'h3, 1, 0, 0);
      drain();
      check("basic_ovf_cnt", 128'(ovf_cnt), 128'(0));
      check("basic_squash_cnt", 128'(squash_cnt), 128'(0));

      // Full / overflow
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) push(66'(32'h10 + i), i < 8, 0, 0);
      check("full_count", 128'(count), 128'(8));
      check("full_overflow", 128'(overflow), 128'(1));
      check("full_ovf_cnt", 128'(ovf_cnt), 128'(2));
      drain();

      // Epoch squash
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(66'(32'h20 + i), 0, 0, 0);
      en_update_eepoch = 1'b1;
      tick();
      en_update_eepoch = 1'b0;
      check("squash_count_pre", 128'(count), 128'(4));
      for (int i = 0; i < 4; i++) begin
         check("squash_no_valid", 128'(out_valid), 128'(0));
         tick();
      end
      check("squash_count_post", 128'(count), 128'(0));
      check("squash_cnt_4", 128'(squash_cnt), 128'(4));
      out_ready = 1'b1;
      push(66'h24, 1, 1, 0);
      check("squash_new_tag_e", 128'(out_eepoch), 128'(1));
      drain();

      // Push, wEpoch toggle and pop of a current head in one cycle
      out_ready = 1'b0;
      push(66'h30, 1, 1, 0);
      out_ready = 1'b1;
      en_update_wepoch = 1'b1;
      push(66'h31, 0, 1, 0);
      en_update_wepoch = 1'b0;
      check("simul_count", 128'(count), 128'(1));
      check("simul_stale_head", 128'(out_valid), 128'(0));
      check("simul_tag_w", 128'(out_wepoch), 128'(0));
      check("simul_squash_pre", 128'(squash_cnt), 128'(4));
      tick();
      check("simul_squash_post", 128'(squash_cnt), 128'(5));
      check("simul_count_post", 128'(count), 128'(0));

      // Reset mid-operation
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(66'(32'h40 + i), 0, 1, 1);
      check("midrst_count_pre", 128'(count), 128'(5));
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      check("midrst_count", 128'(count), 128'(0));
      check("midrst_out_valid", 128'(out_valid), 128'(0));
      check("midrst_overflow", 128'(overflow), 128'(0));
      check("midrst_ovf_cnt", 128'(ovf_cnt), 128'(0));
      check("midrst_squash_cnt", 128'(squash_cnt), 128'(0));
      out_ready = 1'b1;
      push(66'h50, 1, 0, 0);
      drain();

      // Saturation and clear
      out_ready = 1'b0;
      for (int i = 0; i < 28; i++) push(66'(32'h60 + i), i < 8, 0, 0);
      check("sat_ovf_cnt", 128'(ovf_cnt), 128'(15));
      check("sat_overflow", 128'(overflow), 128'(1));
      clr_stats = 1'b1;
      push(66'h99, 0, 0, 0);
      clr_stats = 1'b0;
      check("clr_ovf_cnt", 128'(ovf_cnt), 128'(0));
      check("clr_overflow", 128'(overflow), 128'(0));
      push(66'h9a, 0, 0, 0);
      check("post_clr_ovf_cnt", 128'(ovf_cnt), 128'(1));
      check("post_clr_overflow", 128'(overflow), 128'(1));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
